// File: rtl/led_input_debounce.sv
// Per-bit debouncer: 2-flop synchronizer, saturating acceptance counter, registered level and edge pulses.
// Optional macro DEBOUNCE_EDGE_EN builds the rise/fall pulse registers; otherwise those ports are tied to 0.
module led_input_debounce #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_stable;
    logic [CNT_W-1:0] r_cnt     [WIDTH];
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] w_cnt_nz;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = '0;
            w_accept[i]  = 1'b0;
            w_cnt_nz[i]  = (r_cnt[i] != '0);
            if (r_s2[i] != r_stable[i]) begin
                if (r_cnt[i] == LP_CNT_LAST) begin
                    w_accept[i] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + LP_CNT_ONE;
                end
            end
        end
    end

    // NOTE: the counter array is reset explicitly; a count surviving reset would fake an acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
            r_stable <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            // An accepted bit always differs from stable, so acceptance is a toggle.
            r_stable <= r_stable ^ w_accept;
        end
    end

`ifdef DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_accept & r_s2;
            r_fall <= w_accept & ~r_s2;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`else
    assign rise = '0;
    assign fall = '0;
`endif

    assign stable = r_stable;
    assign busy   = |w_cnt_nz;

endmodule
